// File: rtl/popcnt_argmax_seq.sv
// Sequential argmax over popcounts: takes InCnt words per frame, reports the index and ones count of the winner.
// Define ARGMAX_TIE_LAST_EN to let the highest index win ties (default: lowest index wins).
module popcnt_argmax_seq #(
    parameter int InCnt  = 4,
    parameter int InWdt  = 8,
    parameter int CntWdt = 16,
    localparam int IdxWdt = $clog2(InCnt)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [InWdt-1:0]  in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [IdxWdt-1:0] out_idx_o,
    output logic [CntWdt-1:0] out_cnt_o
);

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // in_ready_o depends only on state; out_valid_o stays high with stable
    // idx/cnt until out_ready_i is seen, and neither ready nor valid waits
    // combinationally on the other side.

    typedef enum logic {
        COLLECT = 1'b0,
        OUTPUT  = 1'b1
    } state_t;

    localparam logic [IdxWdt-1:0] LastIdx = IdxWdt'(InCnt - 1);

    state_t            state;
    state_t            state_nxt;
    logic              in_fire;
    logic              out_fire;
    logic              last_word;
    logic              take;
    logic [CntWdt-1:0] pop_cnt;
    logic [IdxWdt-1:0] word_cnt;
    logic [CntWdt-1:0] max_cnt;
    logic [IdxWdt-1:0] max_idx;

    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < InWdt; i++) begin
            pop_cnt = pop_cnt + CntWdt'(in_data_i[i]);
        end
    end

    // Word 0 always seeds the running max so no explicit clear is needed per frame.
    always_comb begin
`ifdef ARGMAX_TIE_LAST_EN
        take = (word_cnt == '0) || (pop_cnt >= max_cnt);
`else
        take = (word_cnt == '0) || (pop_cnt > max_cnt);
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        in_fire     = 1'b0;
        out_fire    = 1'b0;
        last_word   = 1'b0;
        case (state)
            COLLECT: begin
                in_ready_o = 1'b1;
                in_fire    = in_valid_i;
                last_word  = in_valid_i && (word_cnt == LastIdx);
                if (last_word) begin
                    state_nxt = OUTPUT;
                end
            end
            OUTPUT: begin
                out_valid_o = 1'b1;
                out_fire    = out_ready_i;
                if (out_ready_i) begin
                    state_nxt = COLLECT;
                end
            end
            default: begin
                state_nxt = COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            word_cnt  <= '0;
            max_cnt   <= '0;
            max_idx   <= '0;
            out_idx_o <= '0;
            out_cnt_o <= '0;
        end else begin
            if (in_fire) begin
                if (take) begin
                    max_cnt <= pop_cnt;
                    max_idx <= word_cnt;
                end
                if (last_word) begin
                    word_cnt  <= '0;
                    out_idx_o <= take ? word_cnt : max_idx;
                    out_cnt_o <= take ? pop_cnt : max_cnt;
                end else begin
                    word_cnt <= word_cnt + IdxWdt'(1);
                end
            end
            if (out_fire) begin
                max_cnt <= '0;
                max_idx <= '0;
            end
        end
    end

endmodule

// File: tb/tb_popcnt_argmax_seq.sv
// Directed bench for popcnt_argmax_seq: table of frames plus stall, gap and reset sequences.
module tb_popcnt_argmax_seq;

    localparam int W = 18;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [1:0]  out_idx;
    logic [15:0] out_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_res_cyc = 0;
    logic [W-1:0] exp_q[$];

    typedef struct {
        string           name;
        logic [3:0][7:0] w;
        logic [1:0]      idx;
        logic [15:0]     cnt;
    } vec_t;

    vec_t vecs[6];

    popcnt_argmax_seq #(.InCnt(4), .InWdt(8), .CntWdt(16)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_idx_o   (out_idx),
        .out_cnt_o   (out_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send_word(input logic [7:0] d);
        int   n;
        logic acc;
        n = 0;
        acc = 1'b0;
        in_valid = 1'b1;
        in_data = d;
        while (!acc && n < 50) begin
            acc = in_ready;
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_word timeout: got in_ready=0, expected 1");
        end
    endtask

    function automatic vec_t mk(input string name, input logic [7:0] w0, input logic [7:0] w1,
                                input logic [7:0] w2, input logic [7:0] w3,
                                input logic [1:0] idx, input logic [15:0] cnt);
        vec_t v;
        v.name = name;
        v.w[0] = w0;
        v.w[1] = w1;
        v.w[2] = w2;
        v.w[3] = w3;
        v.idx = idx;
        v.cnt = cnt;
        return v;
    endfunction

    // Expects to be called at the negedge right after the last word was accepted.
    task automatic expect_result(input string name);
        logic [W-1:0] e;
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, " latency"}, n, 0);
        check({name, " valid"}, int'(out_valid), 1);
        check({name, " in_ready"}, int'(in_ready), 0);
        if (exp_q.size() == 0) begin
            check({name, " scoreboard empty"}, 0, 1);
        end else begin
            e = exp_q.pop_front();
            check({name, " idx"}, int'(out_idx), int'(e[W-1:16]));
            check({name, " cnt"}, int'(out_cnt), int'(e[15:0]));
        end
        last_res_cyc = cyc;
    endtask

    initial begin
        vecs[0] = mk("aa0fff00", 8'hAA, 8'h0F, 8'hFF, 8'h00, 2'd2, 16'd8);
        vecs[1] = mk("55fffe40", 8'h55, 8'hFF, 8'hFE, 8'h40, 2'd1, 16'd8);
`ifdef ARGMAX_TIE_LAST_EN
        vecs[2] = mk("tie0ff03c", 8'h0F, 8'hF0, 8'h3C, 8'h00, 2'd2, 16'd4);
        vecs[4] = mk("tie_ones", 8'h80, 8'h01, 8'h02, 8'h04, 2'd3, 16'd1);
`else
        vecs[2] = mk("tie0ff03c", 8'h0F, 8'hF0, 8'h3C, 8'h00, 2'd0, 16'd4);
        vecs[4] = mk("tie_ones", 8'h80, 8'h01, 8'h02, 8'h04, 2'd0, 16'd1);
`endif
        vecs[3] = mk("zeros", 8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 16'd0);
        vecs[5] = mk("last_max", 8'h00, 8'h00, 8'h00, 8'hFF, 2'd3, 16'd8);

        repeat (3) @(negedge clk);
        check("reset out_valid", int'(out_valid), 0);
        check("reset out_idx", int'(out_idx), 0);
        check("reset out_cnt", int'(out_cnt), 0);
        rst = 1'b0;
        @(negedge clk);
        check("post-reset in_ready", int'(in_ready), 1);

        // Back-to-back frames with out_ready held high.
        for (int i = 0; i < 6; i++) begin
            int prev;
            prev = last_res_cyc;
            exp_q.push_back({vecs[i].idx, vecs[i].cnt});
            for (int k = 0; k < 4; k++) send_word(vecs[i].w[k]);
            expect_result(vecs[i].name);
            if (i > 0) check({vecs[i].name, " spacing"}, last_res_cyc - prev, 5);
        end
        @(negedge clk);
        check("handshake clears valid", int'(out_valid), 0);

        // All-zero frame with a 3-cycle valid gap between words 1 and 2.
        exp_q.push_back({2'd0, 16'd0});
        send_word(8'h00);
        send_word(8'h00);
        repeat (3) @(negedge clk);
        check("gap in_ready", int'(in_ready), 1);
        check("gap out_valid", int'(out_valid), 0);
        send_word(8'h00);
        send_word(8'h00);
        expect_result("zeros_gap");
        @(negedge clk);

        // Output stall: result must hold for 5 cycles of out_ready low.
        out_ready = 1'b0;
        exp_q.push_back({2'd3, 16'd4});
        send_word(8'h01);
        send_word(8'h03);
        send_word(8'h07);
        send_word(8'h0F);
        expect_result("stall");
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("stall hold valid", int'(out_valid), 1);
            check("stall hold idx", int'(out_idx), 3);
            check("stall hold cnt", int'(out_cnt), 4);
            check("stall hold in_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("stall release valid", int'(out_valid), 0);
        check("stall release in_ready", int'(in_ready), 1);

        // Reset mid-frame discards the partial max.
        send_word(8'hFF);
        send_word(8'hFF);
        rst = 1'b1;
        @(negedge clk);
        check("midreset out_valid", int'(out_valid), 0);
        rst = 1'b0;
        @(negedge clk);
        check("midreset in_ready", int'(in_ready), 1);
        exp_q.push_back({2'd1, 16'd1});
        send_word(8'h00);
        send_word(8'h01);
        send_word(8'h00);
        send_word(8'h00);
        expect_result("after_reset");
        @(negedge clk);
        check("scoreboard drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
